// File: rtl/exec_status_unit_pkg.sv
// Shared definitions for the execution/status slice.
// Holds the default word, tag and table sizes, the "ready" tag, the entry
// record type used by the issue logic, and a helper that builds a
// reset-state entry.
package exec_status_unit_pkg;

    localparam int                WORD_SIZE = 32;
    localparam int                UNIT_SIZE = 8;
    localparam int                NREG      = 64;
    localparam logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F;

    // Register index width is fixed by the port list, independent of NREG.
    localparam int                ADDR_W    = 6;

    typedef struct packed {
        logic [UNIT_SIZE-1:0] tag;
        logic [WORD_SIZE-1:0] value;
    } rs_entry_t;

    // Entry state seen after reset: no pending producer, value zero.
    function automatic rs_entry_t ready_entry();
        rs_entry_t e;
        e.tag   = READY_TAG;
        e.value = '0;
        return e;
    endfunction

endpackage

// File: rtl/exec_status_unit_reg_status_table.sv
// reg_status_table: per-register status table (tag + value per entry).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   addr             register index shared by the read and write ports
//   we               write strobe for entry addr
//   tag_in, val_in   tag to record; value recorded only for READY_TAG
//   cdb_valid        result broadcast valid
//   cdb_tag          producing unit tag
//   cdb_value        broadcast result
//   tag_out, val_out asynchronous read of entry addr
//
// Indices at or above NREG read back as READY_TAG/0 and never write.
module reg_status_table
    import exec_status_unit_pkg::*;
#(
    parameter int                     WORD_SIZE = exec_status_unit_pkg::WORD_SIZE,
    parameter int                     UNIT_SIZE = exec_status_unit_pkg::UNIT_SIZE,
    parameter int                     NREG      = exec_status_unit_pkg::NREG,
    parameter logic [UNIT_SIZE-1:0]   READY_TAG = exec_status_unit_pkg::READY_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [UNIT_SIZE-1:0]  tag_in,
    input  logic [WORD_SIZE-1:0]  val_in,
    input  logic                  cdb_valid,
    input  logic [UNIT_SIZE-1:0]  cdb_tag,
    input  logic [WORD_SIZE-1:0]  cdb_value,
    output logic [UNIT_SIZE-1:0]  tag_out,
    output logic [WORD_SIZE-1:0]  val_out
);

    logic [UNIT_SIZE-1:0] tag_q [NREG];
    logic [WORD_SIZE-1:0] val_q [NREG];

    logic cdb_hit;
    logic addr_ok;

    // A broadcast carrying the ready tag would otherwise match every idle
    // entry and overwrite committed values, so it is dropped here.
    assign cdb_hit = cdb_valid && (cdb_tag != READY_TAG);
    assign addr_ok = (32'(addr) < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                tag_q[i] <= READY_TAG;
                val_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // Direct write has priority over a broadcast to the same entry.
                if (we && (addr == ADDR_W'(i))) begin
                    tag_q[i] <= tag_in;
                    if (tag_in == READY_TAG) begin
                        val_q[i] <= val_in;
                    end
                end else if (cdb_hit && (tag_q[i] == cdb_tag)) begin
                    tag_q[i] <= READY_TAG;
                    val_q[i] <= cdb_value;
                end
            end
        end
    end

    always_comb begin
        tag_out = READY_TAG;
        val_out = '0;
        if (addr_ok) begin
            tag_out = tag_q[addr];
            val_out = val_q[addr];
        end
    end

endmodule

// File: rtl/exec_status_unit.sv
// exec_status_unit: combinational adder and multiplier plus the register
// status table tracking which unit will produce each register's value.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   add_a, add_b / add_out   wrapping signed sum (no reset dependency)
//   mul_a, mul_b / mul_out   low WORD_SIZE bits of signed product
//   rrs_addr, rrs_we         table index and write strobe
//   rrs_tag_in, rrs_val_in   write data
//   cdb_valid/tag/value      result broadcast
//   rrs_tag_out/val_out      asynchronous read of entry rrs_addr
module exec_status_unit
    import exec_status_unit_pkg::*;
#(
    parameter int                     WORD_SIZE = exec_status_unit_pkg::WORD_SIZE,
    parameter int                     UNIT_SIZE = exec_status_unit_pkg::UNIT_SIZE,
    parameter int                     NREG      = exec_status_unit_pkg::NREG,
    parameter logic [UNIT_SIZE-1:0]   READY_TAG = exec_status_unit_pkg::READY_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  add_a,
    input  logic [WORD_SIZE-1:0]  add_b,
    output logic [WORD_SIZE-1:0]  add_out,
    input  logic [WORD_SIZE-1:0]  mul_a,
    input  logic [WORD_SIZE-1:0]  mul_b,
    output logic [WORD_SIZE-1:0]  mul_out,
    input  logic [ADDR_W-1:0]     rrs_addr,
    input  logic                  rrs_we,
    input  logic [UNIT_SIZE-1:0]  rrs_tag_in,
    input  logic [WORD_SIZE-1:0]  rrs_val_in,
    input  logic                  cdb_valid,
    input  logic [UNIT_SIZE-1:0]  cdb_tag,
    input  logic [WORD_SIZE-1:0]  cdb_value,
    output logic [UNIT_SIZE-1:0]  rrs_tag_out,
    output logic [WORD_SIZE-1:0]  rrs_val_out
);

    assign add_out = add_a + add_b;

    // The low WORD_SIZE bits of a two's-complement product do not depend
    // on operand signedness, so a plain truncated multiply is exact.
    assign mul_out = mul_a * mul_b;

    reg_status_table #(
        .WORD_SIZE (WORD_SIZE),
        .UNIT_SIZE (UNIT_SIZE),
        .NREG      (NREG),
        .READY_TAG (READY_TAG)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .addr      (rrs_addr),
        .we        (rrs_we),
        .tag_in    (rrs_tag_in),
        .val_in    (rrs_val_in),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .tag_out   (rrs_tag_out),
        .val_out   (rrs_val_out)
    );

endmodule

// File: tb/tb_exec_status_unit.sv
`timescale 1ns/10ps
module tb_exec_status_unit;

    localparam logic [7:0] RDY = 8'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] add_a, add_b, add_out;
    logic [31:0] mul_a, mul_b, mul_out;
    logic [5:0]  rrs_addr;
    logic        rrs_we;
    logic [7:0]  rrs_tag_in;
    logic [31:0] rrs_val_in;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [7:0]  rrs_tag_out;
    logic [31:0] rrs_val_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what each register "knows" about its producer.
    logic [7:0]  m_tag [64];
    logic [31:0] m_val [64];

    exec_status_unit dut (
        .clk(clk), .rst(rst),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rrs_addr(rrs_addr), .rrs_we(rrs_we),
        .rrs_tag_in(rrs_tag_in), .rrs_val_in(rrs_val_in),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rrs_tag_out(rrs_tag_out), .rrs_val_out(rrs_val_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = RDY;
            m_val[i] = 0;
        end
    endtask

    // One clock: update the model from the rules using current inputs,
    // then let the DUT see the edge and sample 1ns later.
    task automatic tick();
        logic [7:0]  nt [64];
        logic [31:0] nv [64];
        for (int i = 0; i < 64; i++) begin
            nt[i] = m_tag[i];
            nv[i] = m_val[i];
            if (!rst) begin
                if (cdb_valid && cdb_tag != RDY && m_tag[i] == cdb_tag) begin
                    nt[i] = RDY;
                    nv[i] = cdb_value;
                end
                if (rrs_we && int'(rrs_addr) == i) begin
                    nt[i] = rrs_tag_in;
                    if (rrs_tag_in == RDY) nv[i] = rrs_val_in;
                    else                   nv[i] = m_val[i];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = nt[i];
            m_val[i] = nv[i];
        end
    endtask

    task automatic idle();
        rrs_we    = 0;
        cdb_valid = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] t, input logic [31:0] v);
        rrs_we = 1; rrs_addr = a; rrs_tag_in = t; rrs_val_in = v;
        tick();
        rrs_we = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            rrs_addr = 6'(i);
            #0.05;
            n_tests++;
            if (rrs_tag_out !== RDY || rrs_val_out !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_entry[%0d]: got tag %h val %h, want %h/0", i, rrs_tag_out, rrs_val_out, RDY);
            end
        end
    endtask

    task automatic test_adder();
        logic [31:0] ea [4] = '{32'h7FFFFFFF, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF};
        logic [31:0] eb [4] = '{32'h1,        32'h3,        32'h0, 32'h1};
        logic [31:0] ex [4] = '{32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            add_a = ea[i]; add_b = eb[i]; #1;
            n_tests++;
            if (add_out !== ex[i]) begin
                n_fail++;
                $display("FAIL add_dir[%0d]: got %h want %h", i, add_out, ex[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            longint s;
            add_a = $urandom; add_b = $urandom; #1;
            s = longint'({32'b0, add_a}) + longint'({32'b0, add_b});
            n_tests++;
            if (add_out !== s[31:0]) begin
                n_fail++;
                $display("FAIL add_rand: %h+%h got %h want %h", add_a, add_b, add_out, s[31:0]);
            end
        end
    endtask

    task automatic test_multiplier();
        logic [31:0] ea [3] = '{32'hFFFFFFF9, 32'h00010000, 32'h80000000};
        logic [31:0] eb [3] = '{32'd6,        32'h00010000, 32'hFFFFFFFF};
        logic [31:0] ex [3] = '{32'hFFFFFFD6, 32'h0,        32'h80000000};
        for (int i = 0; i < 3; i++) begin
            mul_a = ea[i]; mul_b = eb[i]; #1;
            n_tests++;
            if (mul_out !== ex[i]) begin
                n_fail++;
                $display("FAIL mul_dir[%0d]: got %h want %h", i, mul_out, ex[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            longint p;
            mul_a = $urandom; mul_b = $urandom; #1;
            p = longint'(signed'(mul_a)) * longint'(signed'(mul_b));
            n_tests++;
            if (mul_out !== p[31:0]) begin
                n_fail++;
                $display("FAIL mul_rand: %h*%h got %h want %h", mul_a, mul_b, mul_out, p[31:0]);
            end
        end
    endtask

    task automatic test_write_read();
        rrs_addr = 5; #0.5;
        n_tests++;
        if (rrs_tag_out !== RDY || rrs_val_out !== 0) begin
            n_fail++;
            $display("FAIL rd5_init: got %h/%0d want 7f/0", rrs_tag_out, rrs_val_out);
        end
        // Read returns stored contents, not same-cycle write data.
        rrs_we = 1; rrs_tag_in = RDY; rrs_val_in = 123; #0.5;
        n_tests++;
        if (rrs_val_out !== 0) begin
            n_fail++;
            $display("FAIL rd5_no_bypass: got %0d want 0", rrs_val_out);
        end
        tick(); idle();
        n_tests++;
        if (rrs_tag_out !== RDY || rrs_val_out !== 123) begin
            n_fail++;
            $display("FAIL rd5_written: got %h/%0d want 7f/123", rrs_tag_out, rrs_val_out);
        end
    endtask

    task automatic test_cdb_broadcast();
        wr(3, RDY, 55);
        wr(3, 8'h21, 1000);
        wr(9, 8'h21, 2000);
        rrs_addr = 3; #0.5;
        n_tests++;
        if (rrs_tag_out !== 8'h21 || rrs_val_out !== 55) begin
            n_fail++;
            $display("FAIL pend3: got %h/%0d want 21/55", rrs_tag_out, rrs_val_out);
        end
        rrs_addr = 9; #0.5;
        n_tests++;
        if (rrs_tag_out !== 8'h21 || rrs_val_out !== 0) begin
            n_fail++;
            $display("FAIL pend9: got %h/%0d want 21/0", rrs_tag_out, rrs_val_out);
        end
        // Broadcast with the ready tag must be ignored.
        cdb_valid = 1; cdb_tag = RDY; cdb_value = 777;
        tick();
        rrs_addr = 5; #0.5;
        n_tests++;
        if (rrs_val_out !== 123) begin
            n_fail++;
            $display("FAIL cdb_ready_ignored: got %0d want 123", rrs_val_out);
        end
        cdb_tag = 8'h21; cdb_value = 99;
        tick(); idle();
        for (int k = 0; k < 2; k++) begin
            rrs_addr = (k == 0) ? 6'd3 : 6'd9; #0.5;
            n_tests++;
            if (rrs_tag_out !== RDY || rrs_val_out !== 99) begin
                n_fail++;
                $display("FAIL cdb_hit[%0d]: got %h/%0d want 7f/99", rrs_addr, rrs_tag_out, rrs_val_out);
            end
        end
    endtask

    task automatic test_write_wins();
        wr(4, RDY, 11);
        wr(4, 8'h40, 0);
        wr(6, 8'h40, 0);
        rrs_we = 1; rrs_addr = 4; rrs_tag_in = 8'h45; rrs_val_in = 500;
        cdb_valid = 1; cdb_tag = 8'h40; cdb_value = 7;
        tick(); idle();
        rrs_addr = 4; #0.5;
        n_tests++;
        if (rrs_tag_out !== 8'h45 || rrs_val_out !== 11) begin
            n_fail++;
            $display("FAIL write_wins: got %h/%0d want 45/11", rrs_tag_out, rrs_val_out);
        end
        rrs_addr = 6; #0.5;
        n_tests++;
        if (rrs_tag_out !== RDY || rrs_val_out !== 7) begin
            n_fail++;
            $display("FAIL other_takes_cdb: got %h/%0d want 7f/7", rrs_tag_out, rrs_val_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] tags [5] = '{8'h10, 8'h11, 8'h12, 8'h13, RDY};
        for (int c = 0; c < 400; c++) begin
            rrs_we     = 1'($urandom_range(0, 1));
            rrs_addr   = 6'($urandom);
            rrs_tag_in = tags[$urandom_range(0, 4)];
            rrs_val_in = $urandom;
            cdb_valid  = ($urandom_range(0, 2) == 0);
            cdb_tag    = tags[$urandom_range(0, 4)];
            cdb_value  = $urandom;
            tick();
            n_tests++;
            if (rrs_tag_out !== m_tag[rrs_addr] || rrs_val_out !== m_val[rrs_addr]) begin
                n_fail++;
                $display("FAIL rand_rd cyc %0d addr %0d: got %h/%h want %h/%h", c, rrs_addr,
                         rrs_tag_out, rrs_val_out, m_tag[rrs_addr], m_val[rrs_addr]);
            end
        end
        idle();
        for (int i = 0; i < 64; i++) begin
            rrs_addr = 6'(i); #0.05;
            n_tests++;
            if (rrs_tag_out !== m_tag[i] || rrs_val_out !== m_val[i]) begin
                n_fail++;
                $display("FAIL rand_sweep[%0d]: got %h/%h want %h/%h", i, rrs_tag_out, rrs_val_out, m_tag[i], m_val[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) wr(6'(i * 7), (i % 2 == 0) ? RDY : 8'h33, 32'(i + 1000));
        @(negedge clk); #1;
        rst = 1; #0.1;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            rrs_addr = 6'(i); #0.05;
            n_tests++;
            if (rrs_tag_out !== RDY || rrs_val_out !== 0) begin
                n_fail++;
                $display("FAIL async_rst[%0d]: got %h/%h want 7f/0", i, rrs_tag_out, rrs_val_out);
            end
        end
        // Writes and broadcasts while held in reset have no effect.
        rrs_we = 1; rrs_addr = 2; rrs_tag_in = RDY; rrs_val_in = 42;
        cdb_valid = 1; cdb_tag = 8'h33; cdb_value = 9;
        tick(); tick();
        @(negedge clk);
        rst = 0;
        idle();
        #0.5;
        n_tests++;
        if (rrs_tag_out !== RDY || rrs_val_out !== 0) begin
            n_fail++;
            $display("FAIL rst_write_ignored: got %h/%0d want 7f/0", rrs_tag_out, rrs_val_out);
        end
        wr(2, RDY, 42);
        n_tests++;
        if (rrs_val_out !== 42) begin
            n_fail++;
            $display("FAIL post_rst_write: got %0d want 42", rrs_val_out);
        end
    endtask

    initial begin
        rst = 1;
        add_a = 0; add_b = 0; mul_a = 0; mul_b = 0;
        rrs_addr = 0; rrs_tag_in = 0; rrs_val_in = 0;
        cdb_tag = 0; cdb_value = 0;
        idle();
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst = 0;
        test_adder();
        test_multiplier();
        @(negedge clk);
        test_write_read();
        test_cdb_broadcast();
        test_write_wins();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
